// File: rtl/mips_cpu_pkg.sv
// Shared types and default constants for the multicycle MIPS core.
// Holds the fetch sequencer state encoding and the reset/halt address defaults.
package mips_cpu_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE,
        HALTED
    } fetch_state_t;

    localparam word_t RESET_VECTOR_DEF = 32'hBFC00000;
    localparam word_t HALT_ADDR_DEF    = 32'h00000000;

endpackage

// File: rtl/pc_reg.sv
// Architectural PC register: loads pc_next on an unconditional or taken-branch write.
// Latency 1 cycle; writes are dropped once the core is inactive (halted).
module pc_reg
    import mips_cpu_pkg::*;
#(
    parameter word_t RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic  clk,
    input  logic  reset,
    input  word_t pc_next,
    input  logic  pc_write,
    input  logic  pc_write_cond,
    input  logic  alu_zero,
    input  logic  active,
    output word_t pc
);

    logic load;

    assign load = active & (pc_write | (pc_write_cond & alu_zero));

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else if (load) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register plus Avalon-MM instruction fetch sequencer; halts on a fetch from HALT_ADDR.
// Latency fetch_req->instr_valid is 2 cycles plus one per waitrequest cycle; fetch_req is ignored while a read is outstanding.
// FETCH_ALIGN_CHECK_EN: when defined, a fetch from a misaligned PC halts with a sticky fetch_fault.
module pc_fetch_unit
    import mips_cpu_pkg::*;
#(
    parameter word_t RESET_VECTOR = RESET_VECTOR_DEF,
    parameter word_t HALT_ADDR    = HALT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  word_t       pc_next,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        alu_zero,
    output word_t       pc,
    output word_t       avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  word_t       avm_readdata,
    output word_t       instr,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        active,
    output logic        fetch_fault
);

    fetch_state_t state;
    fetch_state_t next_state;
    word_t        fetch_addr;
    logic         load_addr;
    logic         load_instr;

    pc_reg #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .pc_next       (pc_next),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .alu_zero      (alu_zero),
        .active        (active),
        .pc            (pc)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic set_fault;
`endif

    always_comb begin
        next_state = state;
        load_addr  = 1'b0;
        load_instr = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        set_fault  = 1'b0;
`endif
        case (state)
            // DONE accepts a new request exactly like IDLE so fetches can run back to back.
            IDLE, DONE: begin
                next_state = IDLE;
                if (fetch_req) begin
                    if (pc == HALT_ADDR) begin
                        next_state = HALTED;
`ifdef FETCH_ALIGN_CHECK_EN
                    end else if (pc[1:0] != 2'b00) begin
                        next_state = HALTED;
                        set_fault  = 1'b1;
`endif
                    end else begin
                        next_state = READ;
                        load_addr  = 1'b1;
                    end
                end
            end
            READ: begin
                if (!avm_waitrequest) begin
                    next_state = DONE;
                    load_instr = 1'b1;
                end
            end
            HALTED:  next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    // The bus address comes from fetch_addr, not pc, so PC writes mid-read cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_addr <= '0;
            instr      <= '0;
        end else begin
            state <= next_state;
            if (load_addr) begin
                fetch_addr <= pc;
            end
            if (load_instr) begin
                instr <= avm_readdata;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_fault <= 1'b0;
        end else if (set_fault) begin
            fetch_fault <= 1'b1;
        end
    end
`else
    assign fetch_fault = 1'b0;
`endif

    assign avm_read       = (state == READ);
    assign fetch_busy     = (state == READ);
    assign avm_byteenable = avm_read ? 4'b1111 : 4'b0000;
    assign avm_address    = fetch_addr;
    assign instr_valid    = (state == DONE);
    assign active         = (state != HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, multi-cycle corner sequences, randomized run against a reference model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'hBFC00000;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] pc_next = '0;
    logic        pc_write = 1'b0;
    logic        pc_write_cond = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] pc;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_busy;
    logic        active;
    logic        fetch_fault;

    int n_vec = 0;
    int n_bad = 0;

    pc_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req       (fetch_req),
        .pc_next         (pc_next),
        .pc_write        (pc_write),
        .pc_write_cond   (pc_write_cond),
        .alu_zero        (alu_zero),
        .pc              (pc),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .fetch_busy      (fetch_busy),
        .active          (active),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit req, input bit pw, input bit pwc, input bit az,
                         input bit wr, input logic [31:0] nxt, input logic [31:0] rd);
        reset = r; fetch_req = req; pc_write = pw; pc_write_cond = pwc; alu_zero = az;
        avm_waitrequest = wr; pc_next = nxt; avm_readdata = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a fetch is either outstanding or not; the core is active until it fetches from 0.
    logic [31:0] m_pc, m_instr, m_addr;
    bit          m_out, m_valid, m_active, m_fault;

    task automatic model_step();
        logic [31:0] npc;
        if (reset) begin
            m_pc = RV; m_instr = 0; m_addr = 0;
            m_out = 0; m_valid = 0; m_active = 1; m_fault = 0;
        end else begin
            npc = (m_active && (pc_write || (pc_write_cond && alu_zero))) ? pc_next : m_pc;
            m_valid = 0;
            if (m_out) begin
                if (!avm_waitrequest) begin
                    m_instr = avm_readdata;
                    m_out   = 0;
                    m_valid = 1;
                end
            end else if (m_active && fetch_req) begin
                if (m_pc == 32'h0) begin
                    m_active = 0;
                end else if (ALIGN_EN && m_pc[1:0] != 2'b00) begin
                    m_active = 0;
                    m_fault  = 1;
                end else begin
                    m_out  = 1;
                    m_addr = m_pc;
                end
            end
            m_pc = npc;
        end
    endtask

    task automatic model_compare();
        chk("rnd_pc", pc, m_pc);
        chk("rnd_read", {31'b0, avm_read}, {31'b0, m_out});
        chk("rnd_be", {28'b0, avm_byteenable}, m_out ? 32'hF : 32'h0);
        chk("rnd_busy", {31'b0, fetch_busy}, {31'b0, m_out});
        chk("rnd_addr", avm_address, m_addr);
        chk("rnd_instr", instr, m_instr);
        chk("rnd_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        chk("rnd_active", {31'b0, active}, {31'b0, m_active});
        chk("rnd_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    endtask

    typedef struct {
        bit          rst, req, pw, pwc, az, wr;
        logic [31:0] nxt, rd;
        logic [31:0] e_pc;
        bit          e_read;
        logic [31:0] e_addr, e_instr;
        bit          e_valid, e_active;
    } vec_t;

    vec_t tv[15];

    initial begin
        int seen;
        tv[0]  = '{1,0,0,0,0,0, 32'h0,        32'h0,        RV,           0, 32'h0, 32'h0,        0, 1};
        tv[1]  = '{0,1,0,0,0,0, 32'h0,        32'h24020005, RV,           1, RV,    32'h0,        0, 1};
        tv[2]  = '{0,0,0,0,0,0, 32'h0,        32'h24020005, RV,           0, RV,    32'h24020005, 1, 1};
        tv[3]  = '{0,0,0,0,0,0, 32'h0,        32'h0,        RV,           0, RV,    32'h24020005, 0, 1};
        tv[4]  = '{0,1,0,0,0,1, 32'h0,        32'h0,        RV,           1, RV,    32'h24020005, 0, 1};
        tv[5]  = '{0,0,1,0,0,1, 32'hBFC00010, 32'h0,        32'hBFC00010, 1, RV,    32'h24020005, 0, 1};
        tv[6]  = '{0,0,0,1,0,1, 32'h12345678, 32'h0,        32'hBFC00010, 1, RV,    32'h24020005, 0, 1};
        tv[7]  = '{0,1,0,0,0,0, 32'h0,        32'h8C010004, 32'hBFC00010, 0, RV,    32'h8C010004, 1, 1};
        tv[8]  = '{0,0,0,1,1,0, 32'h0,        32'h0,        32'h0,        0, RV,    32'h8C010004, 0, 1};
        tv[9]  = '{0,1,0,0,0,0, 32'h0,        32'h0,        32'h0,        0, RV,    32'h8C010004, 0, 0};
        tv[10] = '{0,1,1,0,0,0, 32'hBFC00020, 32'h0,        32'h0,        0, RV,    32'h8C010004, 0, 0};
        tv[11] = '{1,0,0,0,0,0, 32'h0,        32'h0,        RV,           0, 32'h0, 32'h0,        0, 1};
        tv[12] = '{0,1,0,0,0,1, 32'h0,        32'h0,        RV,           1, RV,    32'h0,        0, 1};
        tv[13] = '{1,0,0,0,0,0, 32'h0,        32'hDEADBEEF, RV,           0, 32'h0, 32'h0,        0, 1};
        tv[14] = '{0,0,0,0,0,0, 32'h0,        32'hDEADBEEF, RV,           0, 32'h0, 32'h0,        0, 1};

        #1;
        for (int i = 0; i < 15; i++) begin
            drive(tv[i].rst, tv[i].req, tv[i].pw, tv[i].pwc, tv[i].az, tv[i].wr, tv[i].nxt, tv[i].rd);
            tick();
            chk($sformatf("tv%0d_pc", i), pc, tv[i].e_pc);
            chk($sformatf("tv%0d_read", i), {31'b0, avm_read}, {31'b0, tv[i].e_read});
            chk($sformatf("tv%0d_busy", i), {31'b0, fetch_busy}, {31'b0, tv[i].e_read});
            chk($sformatf("tv%0d_be", i), {28'b0, avm_byteenable}, tv[i].e_read ? 32'hF : 32'h0);
            chk($sformatf("tv%0d_addr", i), avm_address, tv[i].e_addr);
            chk($sformatf("tv%0d_instr", i), instr, tv[i].e_instr);
            chk($sformatf("tv%0d_valid", i), {31'b0, instr_valid}, {31'b0, tv[i].e_valid});
            chk($sformatf("tv%0d_active", i), {31'b0, active}, {31'b0, tv[i].e_active});
            chk($sformatf("tv%0d_fault", i), {31'b0, fetch_fault}, 32'h0);
        end

        // Three waitrequest cycles: bus held stable, instr_valid lands 5 edges after the request.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        seen = 0;
        for (int k = 1; k <= 20 && seen == 0; k++) begin
            drive(0, k == 1, 0, 0, 0, k <= 4, 32'h0, 32'h3C1D0001);
            tick();
            if (k <= 4) begin
                chk($sformatf("ws_read_k%0d", k), {31'b0, avm_read}, 32'h1);
                chk($sformatf("ws_addr_k%0d", k), avm_address, RV);
            end
            if (instr_valid) seen = k;
        end
        chk("ws_latency", seen, 5);
        chk("ws_instr", instr, 32'h3C1D0001);

        // Back-to-back: request accepted in the DONE cycle.
        drive(0, 1, 0, 0, 0, 0, 32'h0, 32'h00000020);
        tick();
        chk("b2b_read", {31'b0, avm_read}, 32'h1);
        chk("b2b_valid_low", {31'b0, instr_valid}, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h00000020);
        tick();
        chk("b2b_valid", {31'b0, instr_valid}, 32'h1);
        chk("b2b_instr", instr, 32'h00000020);

        // Misaligned PC fetch.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0, 0, 32'hBFC00002, 0);
        tick();
        drive(0, 1, 0, 0, 0, 1, 32'h0, 0);
        tick();
        chk("align_read", {31'b0, avm_read}, ALIGN_EN ? 32'h0 : 32'h1);
        chk("align_fault", {31'b0, fetch_fault}, ALIGN_EN ? 32'h1 : 32'h0);
        chk("align_active", {31'b0, active}, ALIGN_EN ? 32'h0 : 32'h1);
        if (!ALIGN_EN) chk("align_addr", avm_address, 32'hBFC00002);

        // Randomized run against the reference model.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        model_step();
        #1;
        model_compare();
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] nxt;
            nxt = $urandom;
            if ($urandom_range(0, 7) != 0) nxt[1:0] = 2'b00;
            if ($urandom_range(0, 40) == 0) nxt = 32'h0;
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  nxt, $urandom);
            @(posedge clk);
            model_step();
            #1;
            model_compare();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- PC register plus instruction-fetch sequencer for the multicycle MIPS core.
- Sits directly downstream of the next-PC select mux and consumes its 32-bit next-PC value.
- Holds the architectural PC and, on request from the control FSM, performs an Avalon-MM read at the PC. It latches the returned word into the instruction register.
- Owns the halt condition: the CPU goes inactive on a fetch from address 0.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, fetch address that halts the CPU instead of issuing a read.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  control FSM requests a fetch at the current PC; single-cycle pulse.
- pc_next  in  32  next-PC value from the select mux.
- pc_write  in  1  unconditional PC load.
- pc_write_cond  in  1  conditional PC load; loads only when alu_zero=1.
- alu_zero  in  1  ALU zero flag for branches.
- pc  out  32  current PC register.
- avm_address  out  32  Avalon read address.
- avm_read  out  1  Avalon read strobe.
- avm_byteenable  out  4  always 4'b1111 while avm_read=1, else 4'b0000.
- avm_waitrequest  in  1  Avalon stall.
- avm_readdata  in  32  Avalon read data.
- instr  out  32  instruction register.
- instr_valid  out  1  one-cycle pulse when instr is updated.
- fetch_busy  out  1  high while a fetch is outstanding.
- active  out  1  high until halt.
- fetch_fault  out  1  misalignment fault flag (see Optional Feature); tied 0 without macro.

Behaviour:
- Clock and reset: one clock domain (clk). reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: pc=RESET_VECTOR, instr=0, instr_valid=0, avm_read=0, avm_address=0, avm_byteenable=0, fetch_busy=0, active=1, fetch_fault=0, state=IDLE.
- PC update: pc<=pc_next when (pc_write | (pc_write_cond & alu_zero)) and active=1. This is independent of fetch state.
- Fetch address: captured into an internal fetch_addr register at fetch start. avm_address is driven from fetch_addr, so a PC update during an outstanding fetch never changes the bus address.
- States: IDLE, READ, DONE, HALTED.
- IDLE:
  - fetch_req=1 and pc==HALT_ADDR -> HALTED; active<=0; no bus read.
  - fetch_req=1 otherwise -> READ; fetch_addr<=pc; avm_read<=1; fetch_busy<=1.
  - fetch_req=0 -> stay in IDLE.
- READ:
  - avm_read, avm_address and avm_byteenable are held stable while avm_waitrequest=1.
  - First cycle with avm_waitrequest=0 -> instr<=avm_readdata, avm_read<=0, fetch_busy<=0, go to DONE.
  - Minimum latency from fetch_req to instr_valid is 2 cycles; each waitrequest cycle adds 1.
- DONE: instr_valid=1 for exactly this cycle, then IDLE. A fetch_req in DONE is accepted exactly as in IDLE (back-to-back fetch).
- fetch_req while in READ: ignored; no queuing.
- HALTED: terminal until reset. avm_read=0, active=0, pc frozen, fetch_req ignored, instr holds its last value.
- Reset mid-READ: avm_read drops on the next clock edge and all state returns to reset values. Late readdata is discarded.
- instr is only written on a completed read. It holds its value across IDLE and across PC updates.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A fetch_req with pc[1:0]!=0 issues no bus read and goes to HALTED with fetch_fault<=1 and active<=0.
  - fetch_fault is sticky until reset.
  - The HALT_ADDR check takes priority over the alignment check.
- Undefined:
  - No alignment check; the low PC bits are passed to avm_address unchanged.
  - fetch_fault is constant 0.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - typedef fetch_state_t {IDLE, READ, DONE, HALTED};
  - constants RESET_VECTOR_DEF=32'hBFC00000 and HALT_ADDR_DEF=32'h0;
  - typedef word_t (logic[31:0]).
- One natural sub-module, pc_reg: the PC register with its write-enable logic (pc_write | pc_write_cond&alu_zero, gated by active). The fetch FSM stays in the top module.

Test Plan:
- Reset, then fetch_req with waitrequest=0, readdata=32'h24020005 -> avm_read=1 at 32'hBFC00000 for 1 cycle; instr=32'h24020005 and instr_valid pulses 2 cycles after the request.
- waitrequest held high 3 cycles -> address/read stable all 3 cycles; instr_valid 5 cycles after fetch_req.
- pc_write=1 with pc_next=32'hBFC00010 during READ -> avm_address stays 32'hBFC00000; pc=32'hBFC00010 next cycle. pc_write_cond=1 with alu_zero=0 -> pc unchanged.
- pc_next=0 loaded, then fetch_req -> no avm_read; active=0 next cycle; further fetch_req and pc_write ignored.
- reset asserted during READ -> avm_read=0 and pc=32'hBFC00000 after the next edge; no instr_valid.
- With FETCH_ALIGN_CHECK_EN, pc=32'hBFC00002 and fetch_req -> no read; fetch_fault=1 and active=0. Without the macro -> read issued at 32'hBFC00002.
